// File: rtl/dram_slot_arbiter_if.sv
// rtl/dram_slot_arbiter_if.sv - video, Z80 and DRAM-sequencer signal bundle for dram_slot_arbiter
interface dram_slot_arbiter_if;
    logic        vid_req;
    logic [19:0] vid_addr;
    logic        vid_next;
    logic        vid_strobe;
    logic [15:0] vid_rddata;

    logic        cpu_req;
    logic        cpu_rnw;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_next;
    logic        cpu_strobe;
    logic [7:0]  cpu_rddata;

    logic        dram_req;
    logic        dram_rfsh;
    logic        dram_rnw;
    logic [19:0] dram_addr;
    logic [1:0]  dram_bsel;
    logic [15:0] dram_wrdata;
    logic [15:0] dram_rddata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, dram_rddata,
        output vid_next, vid_strobe, vid_rddata, cpu_next, cpu_strobe, cpu_rddata,
        output dram_req, dram_rfsh, dram_rnw, dram_addr, dram_bsel, dram_wrdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, dram_rddata,
        input  vid_next, vid_strobe, vid_rddata, cpu_next, cpu_strobe, cpu_rddata,
        input  dram_req, dram_rfsh, dram_rnw, dram_addr, dram_bsel, dram_wrdata
    );
endinterface

// File: rtl/dram_slot_arbiter.sv
// rtl/dram_slot_arbiter.sv - 4-fclk DRAM slot arbiter for video, Z80 and refresh
// Optional: define ARB_RFSH_DEFER_EN to let a single pending refresh yield to the CPU.
module dram_slot_arbiter #(
    parameter int RFSH_CYCLES   = 109,
    parameter int RFSH_PEND_MAX = 3
) (
    input  logic                 fclk,
    input  logic                 rst_n,
    dram_slot_arbiter_if.slave   bus,
    output logic [1:0]           cycle_phase,
    output logic                 rfsh_ovf
);
    localparam int DIV_W  = $clog2(RFSH_CYCLES);
    localparam int PEND_W = $clog2(RFSH_PEND_MAX + 1);

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_RFSH = 2'd3
    } grant_t;

    logic [1:0]        phase;
    logic [DIV_W-1:0]  rfsh_div;
    logic [PEND_W-1:0] pending;
    grant_t            grant;
    logic              arb;
    logic              tick;
    logic              rfsh_gnt;
    logic              own_vid_rd;
    logic              own_cpu_rd;
    logic              own_cpu_lo;

    assign arb         = (phase == 2'd3);
    assign tick        = arb && (rfsh_div == DIV_W'(RFSH_CYCLES - 1));
    assign rfsh_gnt    = arb && (grant == GNT_RFSH);
    assign cycle_phase = phase;

    always_comb begin
        grant = GNT_IDLE;
`ifdef ARB_RFSH_DEFER_EN
        if (bus.vid_req)
            grant = GNT_VID;
        else if (pending > PEND_W'(1))
            grant = GNT_RFSH;
        else if (bus.cpu_req)
            grant = GNT_CPU;
        else if (pending != '0)
            grant = GNT_RFSH;
`else
        if (bus.vid_req)
            grant = GNT_VID;
        else if (pending != '0)
            grant = GNT_RFSH;
        else if (bus.cpu_req)
            grant = GNT_CPU;
`endif
    end

    always_comb begin
        bus.vid_next = arb && (grant == GNT_VID);
        bus.cpu_next = arb && (grant == GNT_CPU);
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 2'd0;
            rfsh_div <= '0;
            pending  <= '0;
            rfsh_ovf <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            if (arb)
                rfsh_div <= tick ? '0 : rfsh_div + DIV_W'(1);
            // a tick and a grant in the same cycle cancel out
            if (tick && !rfsh_gnt) begin
                if (pending == PEND_W'(RFSH_PEND_MAX))
                    rfsh_ovf <= 1'b1;
                else
                    pending <= pending + PEND_W'(1);
            end else if (rfsh_gnt && !tick) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

    // Slot ownership is latched on the edge entering phase 0 and held for the whole cycle.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dram_req    <= 1'b0;
            bus.dram_rfsh   <= 1'b0;
            bus.dram_rnw    <= 1'b1;
            bus.dram_addr   <= '0;
            bus.dram_bsel   <= 2'b00;
            bus.dram_wrdata <= '0;
            own_vid_rd      <= 1'b0;
            own_cpu_rd      <= 1'b0;
            own_cpu_lo      <= 1'b0;
        end else if (arb) begin
            own_vid_rd <= (grant == GNT_VID);
            own_cpu_rd <= (grant == GNT_CPU) && bus.cpu_rnw;
            case (grant)
                GNT_VID: begin
                    bus.dram_req  <= 1'b1;
                    bus.dram_rfsh <= 1'b0;
                    bus.dram_rnw  <= 1'b1;
                    bus.dram_addr <= bus.vid_addr;
                    bus.dram_bsel <= 2'b11;
                end
                GNT_CPU: begin
                    bus.dram_req    <= 1'b1;
                    bus.dram_rfsh   <= 1'b0;
                    bus.dram_rnw    <= bus.cpu_rnw;
                    bus.dram_addr   <= bus.cpu_addr[20:1];
                    bus.dram_bsel   <= bus.cpu_addr[0] ? 2'b01 : 2'b10;
                    bus.dram_wrdata <= {bus.cpu_wrdata, bus.cpu_wrdata};
                    own_cpu_lo      <= bus.cpu_addr[0];
                end
                GNT_RFSH: begin
                    bus.dram_req  <= 1'b0;
                    bus.dram_rfsh <= 1'b1;
                    bus.dram_rnw  <= 1'b1;
                    bus.dram_bsel <= 2'b00;
                end
                default: begin
                    bus.dram_req  <= 1'b0;
                    bus.dram_rfsh <= 1'b0;
                end
            endcase
        end
    end

    // Read data of the current slot is captured at its phase 3; strobes land in phase 0.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vid_strobe <= 1'b0;
            bus.vid_rddata <= '0;
            bus.cpu_strobe <= 1'b0;
            bus.cpu_rddata <= '0;
        end else begin
            bus.vid_strobe <= arb && own_vid_rd;
            bus.cpu_strobe <= arb && own_cpu_rd;
            if (arb && own_vid_rd)
                bus.vid_rddata <= bus.dram_rddata;
            if (arb && own_cpu_rd)
                bus.cpu_rddata <= own_cpu_lo ? bus.dram_rddata[7:0] : bus.dram_rddata[15:8];
        end
    end
endmodule

// File: doc/dram_slot_arbiter.md
# dram_slot_arbiter

Shares the single 16-bit DRAM array (two RAS banks, upper/lower CAS byte lanes) between the video fetcher, the Z80 memory interface and refresh. Time is divided into fixed 4-fclk DRAM cycles. One requester is granted per cycle, and its address and control are presented to the DRAM sequencer for the whole cycle. Read data is returned to the owner with a one-fclk strobe. The block sits between the video/Z80 front ends and the RAS/CAS sequencer in `top`.

## Interface
Parameters:
- RFSH_CYCLES, 109: number of DRAM cycles between refresh ticks. 109 × 4 × 35.6 ns ≈ 15.5 µs.
- RFSH_PEND_MAX, 3: saturation value of the pending-refresh counter.

Ports:
- fclk  in  1  system clock (28 MHz); every register is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video wants one word this cycle.
- vid_addr  in  20  video word address.
- vid_next  out  1  video request accepted; pulse.
- vid_strobe  out  1  vid_rddata valid; pulse.
- vid_rddata  out  16  registered video read word.
- cpu_req  in  1  Z80 access pending.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_addr  in  21  Z80 byte address.
- cpu_wrdata  in  8  write byte.
- cpu_next  out  1  CPU request accepted; pulse.
- cpu_strobe  out  1  cpu_rddata valid; pulse, reads only.
- cpu_rddata  out  8  registered CPU read byte.
- dram_req  out  1  a memory access occupies this cycle.
- dram_rfsh  out  1  a CAS-before-RAS refresh occupies this cycle.
- dram_rnw  out  1  access direction.
- dram_addr  out  20  word address to the sequencer.
- dram_bsel  out  2  byte lanes. [1] = upper (15:8), [0] = lower (7:0).
- dram_wrdata  out  16  write data.
- dram_rddata  in  16  sequencer read data, valid at phase 3.
- cycle_phase  out  2  current phase, 0..3.
- rfsh_ovf  out  1  sticky flag: a refresh tick was lost at saturation.

## Operation
- A 2-bit phase counter runs 0→1→2→3→0 continuously. A DRAM cycle is phases 0..3.
- Arbitration happens at phase 3 of cycle N. The grant owns cycle N+1.
- Priority without the macro: video > refresh (pending ≥ 1) > CPU > idle.
- Requesters hold req and address stable until their next pulse. Dropping req before the grant withdraws the request, and no access is made.
- CPU byte mapping: dram_addr = cpu_addr[20:1].
  - cpu_addr[0] = 0 selects bsel 2'b10; cpu_addr[0] = 1 selects bsel 2'b01.
  - dram_wrdata = {cpu_wrdata, cpu_wrdata}.
  - Reads return the selected byte.
- Video accesses are always reads with bsel 2'b11.
- During a refresh cycle: dram_rfsh = 1, dram_req = 0, dram_rnw = 1, bsel = 2'b00.
- During an idle cycle: dram_req = 0, dram_rfsh = 0. The address holds its previous value.
- Refresh divider: counts DRAM cycles 0..RFSH_CYCLES-1 and ticks at wrap.
- Pending-refresh counter:
  - A tick increments it.
  - A refresh grant decrements it.
  - A tick and a grant in the same cycle leave it unchanged.
  - A tick at RFSH_PEND_MAX without a grant leaves it saturated and sets rfsh_ovf. rfsh_ovf clears only on reset.

## Timing
- Reset: phase = 0, divider = 0, pending = 0. Every output is 0, except dram_rnw = 1.
- vid_next / cpu_next: high for exactly the phase-3 fclk of arbitration cycle N.
- dram_*: registered. They change on the edge entering phase 0 of cycle N+1 and are stable through phase 3.
- Read return: dram_rddata is sampled at phase 3 of cycle N+1. The strobe and rddata register are high/updated during phase 0 of cycle N+2. Latency from the next pulse to the strobe is 5 fclk.
- Writes produce no strobe.
- Reset asserted mid-cycle aborts immediately. Any return in flight is lost, and no strobe is issued after reset is released.
- Back-to-back grants to the same requester are allowed on consecutive cycles.

## Configuration
- ARB_RFSH_DEFER_EN defined: refresh with pending = 1 yields to the CPU.
  - Priority becomes video > refresh (pending ≥ 2) > CPU > refresh (pending ≥ 1) > idle.
  - Refresh is therefore taken in cycles where neither video nor CPU requests.
- ARB_RFSH_DEFER_EN undefined: the priority given under Operation applies.

## Test plan
- Reset, then no requests for 109 DRAM cycles → the first dram_rfsh cycle starts at fclk 4·109+4 after reset release; pending returns to 0.
- cpu_req = 1, cpu_rnw = 1, cpu_addr = 21'h000101, sequencer returns 16'hA55A → bsel = 2'b01, dram_addr = 20'h00080, cpu_rddata = 8'h5A, strobe 5 fclk after cpu_next.
- CPU write, cpu_addr = 21'h000100, cpu_wrdata = 8'h3C → dram_rnw = 0, bsel = 2'b10, dram_wrdata = 16'h3C3C, no cpu_strobe.
- vid_req and cpu_req held high together → video is granted every cycle and cpu_next never pulses. Release vid_req → CPU is granted at the next phase 3.
- Pending = 1 with cpu_req held high → without the macro, refresh is granted first. With ARB_RFSH_DEFER_EN, the CPU is granted and refresh waits until pending = 2.
- Video held high for 5 refresh periods → pending saturates at 3 and rfsh_ovf = 1 after the 4th tick; rfsh_ovf remains 1 until rst_n goes low.
